// File: rtl/seg7_capture.sv
// Two-channel 7-segment pattern capture: synchronize, qualify stability, decode back to a digit.
// Optional build macro SEG_CAPTURE_HEX_EN adds the A-F glyphs to the decode table.
module seg7_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_u,
    input  logic [6:0] seg_d,
    output logic [3:0] val_u,
    output logic [3:0] val_d,
    output logic       err_u,
    output logic       err_d,
    output logic       mismatch,
    output logic       upd
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    // Channel 0 is units, channel 1 is tenths.
    logic [1:0][6:0]    seg_in;
    logic [1:0][6:0]    sync_q;
    logic [1:0][6:0]    samp;
    logic [1:0][6:0]    samp_prev;
    logic [1:0][CW-1:0] cnt;
    logic [1:0][CW-1:0] cnt_nxt;
    logic [1:0]         commit;
    logic [1:0][4:0]    dec;
    logic [4:0]         tup_u;
    logic [4:0]         tup_d;

    assign seg_in = {seg_d, seg_u};

    // Returns {err, val}; unknown glyphs map to err=1, val=0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
`ifdef SEG_CAPTURE_HEX_EN
            7'b1110111: decode = 5'h0A;
            7'b0011111: decode = 5'h0B;
            7'b1001110: decode = 5'h0C;
            7'b0111101: decode = 5'h0D;
            7'b1001111: decode = 5'h0E;
            7'b1000111: decode = 5'h0F;
`endif
            default:    decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cnt_nxt = cnt;
        commit  = '0;
        dec     = '0;
        for (int ch = 0; ch < 2; ch++) begin
            dec[ch] = decode(samp[ch]);
            if (samp[ch] != samp_prev[ch])
                cnt_nxt[ch] = CW'(1);
            else if (cnt[ch] != CNT_MAX)
                cnt_nxt[ch] = cnt[ch] + CW'(1);
            // A fresh pattern also commits when one sample is enough to qualify.
            commit[ch] = (cnt_nxt[ch] == CNT_MAX) &&
                         ((cnt[ch] != CNT_MAX) || (samp[ch] != samp_prev[ch]));
        end
        tup_u = commit[0] ? dec[0] : {err_u, val_u};
        tup_d = commit[1] ? dec[1] : {err_d, val_d};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            samp      <= '0;
            samp_prev <= '0;
            cnt       <= '0;
            val_u     <= 4'h0;
            val_d     <= 4'h0;
            err_u     <= 1'b1;
            err_d     <= 1'b1;
            upd       <= 1'b0;
        end else begin
            sync_q    <= seg_in;
            samp      <= sync_q;
            samp_prev <= samp;
            cnt       <= cnt_nxt;
            {err_u, val_u} <= tup_u;
            {err_d, val_d} <= tup_d;
            upd       <= ({tup_u, tup_d} != {err_u, val_u, err_d, val_d});
        end
    end

    assign mismatch = ~err_u & ~err_d & (val_u != val_d);

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a window-based reference model predicts every committed
// tuple and upd pulse; a negedge monitor compares the DUT against it.
module tb_seg7_capture;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_u, seg_d;
    logic [3:0] val_u, val_d;
    logic       err_u, err_d, mismatch, upd;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_u(seg_u), .seg_d(seg_d),
        .val_u(val_u), .val_d(val_d), .err_u(err_u), .err_d(err_d),
        .mismatch(mismatch), .upd(upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] vu;
        logic       eu;
        logic [3:0] vd;
        logic       ed;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Glyph for each digit value, 0..F.
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

`ifdef SEG_CAPTURE_HEX_EN
    localparam int NV = 16;
`else
    localparam int NV = 10;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int v = 0; v < NV; v++)
            if (glyph[v] == p) return {1'b0, 4'(v)};
        return 5'h10;
    endfunction

    // A pattern qualifies when the last S processed samples are identical and the sample
    // before that window (if any) was different.
    function automatic bit qualifies(input logic [6:0] w[$]);
        int n = w.size();
        if (n < S) return 1'b0;
        for (int i = n - S; i < n; i++)
            if (w[i] !== w[n-1]) return 1'b0;
        if (n > S && w[n-S-1] === w[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: two-deep input pipeline, sliding window of processed samples.
    logic [6:0] pu[$], pd[$], wu[$], wd[$];
    int         e, last_edge;
    logic [3:0] m_vu, m_vd;
    logic       m_eu, m_ed;

    always @(posedge clk or posedge rst) begin
        logic [6:0] cu, cd;
        logic [4:0] nu, nd;
        if (rst) begin
            pu = '{7'h0, 7'h0};
            pd = '{7'h0, 7'h0};
            wu.delete();
            wd.delete();
            sb.delete();
            e = 0;
            last_edge = -1;
            m_vu = 4'h0; m_eu = 1'b1;
            m_vd = 4'h0; m_ed = 1'b1;
        end else begin
            cu = pu.pop_front(); pu.push_back(seg_u);
            cd = pd.pop_front(); pd.push_back(seg_d);
            wu.push_back(cu); if (wu.size() > S + 1) void'(wu.pop_front());
            wd.push_back(cd); if (wd.size() > S + 1) void'(wd.pop_front());
            nu = {m_eu, m_vu};
            nd = {m_ed, m_vd};
            if (qualifies(wu)) nu = ref_decode(cu);
            if (qualifies(wd)) nd = ref_decode(cd);
            if ({nu, nd} != {m_eu, m_vu, m_ed, m_vd})
                sb.push_back('{cyc: e, vu: nu[3:0], eu: nu[4], vd: nd[3:0], ed: nd[4]});
            {m_eu, m_vu} = nu;
            {m_ed, m_vd} = nd;
            last_edge = e;
            e++;
        end
    end

    // Monitor: state compared every cycle; upd must appear exactly on predicted edges.
    always @(negedge clk) begin
        exp_t x;
        check("val_u", val_u, m_vu);
        check("err_u", err_u, m_eu);
        check("val_d", val_d, m_vd);
        check("err_d", err_d, m_ed);
        check("mismatch", mismatch, !m_eu && !m_ed && (m_vu != m_vd));
        if (sb.size() > 0 && sb[0].cyc == last_edge) begin
            x = sb.pop_front();
            check("upd_pulse", upd, 1'b1);
            check("upd_tuple", {err_u, val_u, err_d, val_d}, {x.eu, x.vu, x.ed, x.vd});
        end else begin
            check("upd_idle", upd, 1'b0);
        end
    end

    task automatic hold(input logic [6:0] u, input logic [6:0] d, input int n);
        seg_u = u;
        seg_d = d;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] pick();
        if ($urandom_range(0, 3) == 0) return 7'($urandom);
        return glyph[$urandom_range(0, 15)];
    endfunction

    initial begin
        rst = 1'b1;
        seg_u = 7'h0;
        seg_d = 7'h0;
        repeat (3) @(negedge clk);
        check("rst_val_u", val_u, 4'h0);
        check("rst_err_u", err_u, 1'b1);
        check("rst_err_d", err_d, 1'b1);
        check("rst_upd", upd, 1'b0);
        check("rst_mismatch", mismatch, 1'b0);
        rst = 1'b0;

        hold(7'b0110011, 7'b0110011, S + 6);
        check("t1_val_u", val_u, 4'd4);
        check("t1_val_d", val_d, 4'd4);
        check("t1_mismatch", mismatch, 1'b0);

        hold(7'b0110011, 7'b1111011, S + 6);
        check("t2_val_d", val_d, 4'd9);
        check("t2_val_u", val_u, 4'd4);
        check("t2_mismatch", mismatch, 1'b1);

        hold(7'b1111111, 7'b1111011, 10);
        hold(7'b0110011, 7'b1111011, S + 6);
        check("t3_glitch_val_u", val_u, 4'd4);

        hold(7'b0000000, 7'b1111011, S + 6);
        check("t4_blank_err_u", err_u, 1'b1);
        hold(7'b1010101, 7'b1111011, S + 6);
        check("t4_junk_err_u", err_u, 1'b1);
        check("t4_junk_val_u", val_u, 4'd0);

        hold(7'b1101101, 7'b1101101, S + 6);
        check("t5_val_u", val_u, 4'd2);
        check("t5_val_d", val_d, 4'd2);

        hold(7'b1110111, 7'b1101101, S + 6);
`ifdef SEG_CAPTURE_HEX_EN
        check("t6_hex_val_u", val_u, 4'hA);
        check("t6_hex_err_u", err_u, 1'b0);
`else
        check("t6_hex_val_u", val_u, 4'h0);
        check("t6_hex_err_u", err_u, 1'b1);
`endif

        // Reset in the middle of qualifying a new pattern.
        hold(7'b0110000, 7'b1101101, 8);
        #2 rst = 1'b1;
        @(negedge clk);
        check("t7_rst_val_u", val_u, 4'h0);
        check("t7_rst_err_u", err_u, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        hold(7'b0110000, 7'b1101101, S + 6);
        check("t7_val_u", val_u, 4'd1);
        check("t7_val_d", val_d, 4'd2);

        for (int i = 0; i < 250; i++) begin
            logic [6:0] a, b;
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            hold(a, b, $urandom_range(1, 2 * S));
        end

        hold(seg_u, seg_d, 2 * S + 4);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
